// File: rtl/yolo_params_pkg.sv
// Shared YOLO datapath parameters and pixel/window types used by the
// window generator and the convolution stage it feeds.
package yolo_params_pkg;

    localparam int IP_DATA_WIDTH = 8;
    localparam int IFMAP_SIZE    = 5;
    localparam int FILTER_SIZE   = 3;
    localparam int OFMAP_SIZE    = IFMAP_SIZE - FILTER_SIZE + 1;

    typedef logic [IP_DATA_WIDTH-1:0] pixel_t;
    typedef pixel_t [FILTER_SIZE-1:0][FILTER_SIZE-1:0] window_t;

    // Index width that stays legal when a dimension collapses to a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image row of storage indexed by column; the old entry is read
// combinationally while the new pixel is written at the same address.
module conv_line_buffer #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 5,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming stride-1 sliding-window generator: raster pixels in, one
// FILTER_SIZE x FILTER_SIZE window out per valid output position.
module conv_window_gen #(
    parameter  int IP_DATA_WIDTH = yolo_params_pkg::IP_DATA_WIDTH,
    parameter  int IFMAP_SIZE    = yolo_params_pkg::IFMAP_SIZE,
    parameter  int FILTER_SIZE   = yolo_params_pkg::FILTER_SIZE,
    localparam int OFMAP_SIZE    = IFMAP_SIZE - FILTER_SIZE + 1,
    localparam int OW            = yolo_params_pkg::idx_width(OFMAP_SIZE)
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [IP_DATA_WIDTH-1:0]                              in_data,
    output logic                                                  win_valid,
    input  logic                                                  win_ready,
    output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0] win,
    output logic [OW-1:0]                                         win_row,
    output logic [OW-1:0]                                         win_col,
    output logic                                                  win_last
);

    localparam int PW  = yolo_params_pkg::idx_width(IFMAP_SIZE);
    localparam int NLB = FILTER_SIZE - 1;

    typedef logic [IP_DATA_WIDTH-1:0] px_t;
    typedef px_t [FILTER_SIZE-1:0][FILTER_SIZE-1:0] win_t;

    logic [PW-1:0] row_cnt;
    logic [PW-1:0] col_cnt;
    logic          accept;
    logic          emit;
    logic          col_end;
    logic          row_end;
    px_t           lb_rdata [NLB];
    px_t           lb_wdata [NLB];
    win_t          win_sr;
    win_t          win_nxt;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign col_end  = (col_cnt == PW'(IFMAP_SIZE - 1));
    assign row_end  = (row_cnt == PW'(IFMAP_SIZE - 1));
    assign emit     = accept && (row_cnt >= PW'(FILTER_SIZE - 1))
                             && (col_cnt >= PW'(FILTER_SIZE - 1));

    // Rows cascade upward through the line buffers: each buffer takes the
    // value the buffer below it held for this column, the bottom one takes in_data.
    for (genvar k = 0; k < NLB; k++) begin : g_lb
        if (k == NLB - 1) begin : g_bottom
            assign lb_wdata[k] = in_data;
        end else begin : g_mid
            assign lb_wdata[k] = lb_rdata[k+1];
        end

        conv_line_buffer #(
            .WIDTH (IP_DATA_WIDTH),
            .DEPTH (IFMAP_SIZE)
        ) u_lb (
            .clk   (clk),
            .we    (accept),
            .addr  (col_cnt),
            .wdata (lb_wdata[k]),
            .rdata (lb_rdata[k])
        );
    end

    always_comb begin
        win_nxt = win_sr;
        for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
            for (int unsigned j = 0; j < FILTER_SIZE - 1; j++) begin
                win_nxt[i][j] = win_sr[i][j+1];
            end
        end
        for (int unsigned i = 0; i < NLB; i++) begin
            win_nxt[i][FILTER_SIZE-1] = lb_rdata[i];
        end
        win_nxt[FILTER_SIZE-1][FILTER_SIZE-1] = in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (accept) begin
            if (col_end) begin
                col_cnt <= '0;
                row_cnt <= row_end ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_sr <= '0;
        end else if (accept) begin
            win_sr <= win_nxt;
        end
    end

    // emit implies accept, which implies the output slot is free or being drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid <= 1'b0;
            win       <= '0;
            win_row   <= '0;
            win_col   <= '0;
            win_last  <= 1'b0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win       <= win_nxt;
            win_row   <= OW'(row_cnt - PW'(FILTER_SIZE - 1));
            win_col   <= OW'(col_cnt - PW'(FILTER_SIZE - 1));
            win_last  <= row_end && col_end;
        end else if (win_ready) begin
            win_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: windows are predicted directly
// from the ifmap array and compared in order, with latency and stall checks.
module tb_conv_window_gen;
    import yolo_params_pkg::*;

    localparam int N      = IFMAP_SIZE;
    localparam int K      = FILTER_SIZE;
    localparam int O      = OFMAP_SIZE;
    localparam int OW     = idx_width(O);
    localparam int BUDGET = 3000;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic          win_ready = 1'b1;
    pixel_t        in_data   = '0;
    logic          in_ready;
    logic          win_valid;
    logic          win_last;
    window_t       win;
    logic [OW-1:0] win_row;
    logic [OW-1:0] win_col;

    conv_window_gen dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win       (win),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_last  (win_last)
    );

    always #5 clk = ~clk;

    typedef pixel_t pxq_t[$];
    typedef struct { window_t w; int row; int col; bit last; int trig; }   exp_t;
    typedef struct { window_t w; int row; int col; bit last; int appear; } obs_t;
    typedef exp_t expq_t[$];

    int   asserts = 0;
    int   fails   = 0;
    obs_t obs[$];
    int   acc_cycle[$];
    int   ready_glitches, stall_glitches, stalled, extra;
    bit   timed_out;

    function automatic pxq_t seq(input int start, input int n);
        pxq_t q;
        for (int k = 0; k < n; k++) q.push_back(pixel_t'(start + k));
        return q;
    endfunction

    function automatic pxq_t rnd(input int n);
        pxq_t q;
        for (int k = 0; k < n; k++) q.push_back(pixel_t'($urandom));
        return q;
    endfunction

    // Reference: every stride-1 window of each full frame, in raster order,
    // plus the stream index of the pixel that completes it.
    function automatic expq_t model(input pixel_t px[$]);
        expq_t e;
        int frames = px.size() / (N * N);
        for (int f = 0; f < frames; f++) begin
            for (int r0 = 0; r0 < O; r0++) begin
                for (int c0 = 0; c0 < O; c0++) begin
                    exp_t x;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            x.w[i][j] = px[f*N*N + (r0+i)*N + c0 + j];
                    x.row  = r0;
                    x.col  = c0;
                    x.last = (r0 == O-1) && (c0 == O-1);
                    x.trig = f*N*N + (r0+K-1)*N + c0 + K - 1;
                    e.push_back(x);
                end
            end
        end
        return e;
    endfunction

    task automatic run_stream(input pixel_t px[$], input int expect_n,
                              input int bubble_pct, input int stall_pct, input bit hold5);
        int   sent = 0, cyc = 0, hold = 0, appear = 0;
        bit   prev_valid = 0, prev_cons = 0;
        obs_t snap;
        obs.delete();
        acc_cycle.delete();
        ready_glitches = 0; stall_glitches = 0; stalled = 0; extra = 0; timed_out = 0;
        while ((sent < px.size() || obs.size() < expect_n) && cyc < BUDGET) begin
            @(negedge clk);
            in_valid = (sent < px.size()) && ($urandom_range(99) >= bubble_pct);
            in_data  = (sent < px.size()) ? px[sent] : pixel_t'($urandom);
            if (hold5 && obs.size() == 0 && win_valid && hold < 5) begin
                win_ready = 1'b0;
                hold++;
            end else begin
                win_ready = ($urandom_range(99) >= stall_pct);
            end
            #1;
            if (in_ready !== (!win_valid || win_ready)) ready_glitches++;
            if (prev_valid && !prev_cons) begin
                if (!win_valid || win !== snap.w || int'(win_row) != snap.row ||
                    int'(win_col) != snap.col || win_last !== snap.last)
                    stall_glitches++;
            end
            if (win_valid && (!prev_valid || prev_cons)) appear = cyc;
            if (win_valid && win_ready)
                obs.push_back('{win, int'(win_row), int'(win_col), win_last, appear});
            if (win_valid && !win_ready) stalled++;
            if (in_valid && in_ready) begin
                acc_cycle.push_back(cyc);
                sent++;
            end
            prev_valid = win_valid;
            prev_cons  = win_valid && win_ready;
            snap       = '{win, int'(win_row), int'(win_col), win_last, appear};
            cyc++;
        end
        timed_out = (cyc >= BUDGET);
        @(negedge clk);
        in_valid  = 1'b0;
        win_ready = 1'b1;
        repeat (4) begin
            #1;
            if (win_valid) extra++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; win_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        asserts++;
        if (win_valid !== 1'b0 || win_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: win_valid=%b win_last=%b, required 0 0", win_valid, win_last);
        end
        asserts++;
        if (win_row !== '0 || win_col !== '0) begin
            fails++;
            $display("FAIL reset_pos: row=%0d col=%0d, required 0 0", win_row, win_col);
        end
        asserts++;
        if (win !== '0) begin
            fails++;
            $display("FAIL reset_win: got %h, required 0", win);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        asserts++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single_frame();
        pxq_t  px = seq(1, N*N);
        expq_t e  = model(px);
        int    sum;
        run_stream(px, e.size(), 0, 0, 1'b0);
        asserts++;
        if (timed_out || obs.size() != e.size() || extra != 0) begin
            fails++;
            $display("FAIL single_count: got %0d windows (+%0d extra, timeout=%0b), required %0d",
                     obs.size(), extra, timed_out, e.size());
        end
        asserts++;
        if (ready_glitches != 0) begin
            fails++;
            $display("FAIL single_in_ready: %0d cycles wrong, required 0", ready_glitches);
        end
        for (int i = 0; i < e.size() && i < obs.size(); i++) begin
            asserts++;
            if (obs[i].w !== e[i].w || obs[i].row != e[i].row || obs[i].col != e[i].col ||
                obs[i].last !== e[i].last) begin
                fails++;
                $display("FAIL single_win%0d: got (%0d,%0d) last=%0b %h, required (%0d,%0d) last=%0b %h",
                         i, obs[i].row, obs[i].col, obs[i].last, obs[i].w,
                         e[i].row, e[i].col, e[i].last, e[i].w);
            end
            asserts++;
            if (e[i].trig >= acc_cycle.size() || obs[i].appear != acc_cycle[e[i].trig] + 1) begin
                fails++;
                $display("FAIL single_latency%0d: appeared cycle %0d, required one after pixel %0d",
                         i, obs[i].appear, e[i].trig + 1);
            end
        end
        if (obs.size() == e.size()) begin
            sum = 0;
            for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) sum += 2 * int'(obs[0].w[i][j]);
            asserts++;
            if (sum != 126) begin
                fails++;
                $display("FAIL conv_first: got %0d, required 126", sum);
            end
            sum = 0;
            for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) sum += 2 * int'(obs[O*O-1].w[i][j]);
            asserts++;
            if (sum != 342) begin
                fails++;
                $display("FAIL conv_last: got %0d, required 342", sum);
            end
        end
    endtask

    task automatic test_stall();
        pxq_t  px = seq(1, N*N);
        expq_t e  = model(px);
        run_stream(px, e.size(), 0, 0, 1'b1);
        asserts++;
        if (timed_out || obs.size() != e.size() || extra != 0) begin
            fails++;
            $display("FAIL stall_count: got %0d windows (+%0d extra), required %0d",
                     obs.size(), extra, e.size());
        end
        asserts++;
        if (stalled != 5 || stall_glitches != 0 || ready_glitches != 0) begin
            fails++;
            $display("FAIL stall_hold: stalled=%0d unstable=%0d in_ready_wrong=%0d, required 5 0 0",
                     stalled, stall_glitches, ready_glitches);
        end
        for (int i = 0; i < e.size() && i < obs.size(); i++) begin
            asserts++;
            if (obs[i].w !== e[i].w || obs[i].row != e[i].row || obs[i].col != e[i].col ||
                obs[i].last !== e[i].last ||
                e[i].trig >= acc_cycle.size() || obs[i].appear != acc_cycle[e[i].trig] + 1) begin
                fails++;
                $display("FAIL stall_win%0d: got (%0d,%0d) last=%0b %h @%0d, required (%0d,%0d) last=%0b %h",
                         i, obs[i].row, obs[i].col, obs[i].last, obs[i].w, obs[i].appear,
                         e[i].row, e[i].col, e[i].last, e[i].w);
            end
        end
    endtask

    task automatic test_random();
        for (int run = 0; run < 4; run++) begin
            pxq_t  px = (run == 0) ? seq(1, N*N) : rnd(N*N);
            expq_t e  = model(px);
            run_stream(px, e.size(), 10 + 15*run, 10 + 15*run, 1'b0);
            asserts++;
            if (timed_out || obs.size() != e.size() || extra != 0 ||
                stall_glitches != 0 || ready_glitches != 0) begin
                fails++;
                $display("FAIL random%0d_flow: windows=%0d extra=%0d unstable=%0d in_ready_wrong=%0d, required %0d 0 0 0",
                         run, obs.size(), extra, stall_glitches, ready_glitches, e.size());
            end
            for (int i = 0; i < e.size() && i < obs.size(); i++) begin
                asserts++;
                if (obs[i].w !== e[i].w || obs[i].row != e[i].row || obs[i].col != e[i].col ||
                    obs[i].last !== e[i].last ||
                    e[i].trig >= acc_cycle.size() || obs[i].appear != acc_cycle[e[i].trig] + 1) begin
                    fails++;
                    $display("FAIL random%0d_win%0d: got (%0d,%0d) last=%0b %h, required (%0d,%0d) last=%0b %h",
                             run, i, obs[i].row, obs[i].col, obs[i].last, obs[i].w,
                             e[i].row, e[i].col, e[i].last, e[i].w);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int run = 0; run < 2; run++) begin
            pxq_t  px = (run == 0) ? seq(1, 2*N*N) : rnd(3*N*N);
            expq_t e  = model(px);
            run_stream(px, e.size(), 20*run, 20*run, 1'b0);
            asserts++;
            if (timed_out || obs.size() != e.size() || extra != 0 || stall_glitches != 0) begin
                fails++;
                $display("FAIL b2b%0d_count: got %0d windows (+%0d extra, unstable=%0d), required %0d",
                         run, obs.size(), extra, stall_glitches, e.size());
            end
            for (int i = 0; i < e.size() && i < obs.size(); i++) begin
                asserts++;
                if (obs[i].w !== e[i].w || obs[i].row != e[i].row || obs[i].col != e[i].col ||
                    obs[i].last !== e[i].last ||
                    e[i].trig >= acc_cycle.size() || obs[i].appear != acc_cycle[e[i].trig] + 1) begin
                    fails++;
                    $display("FAIL b2b%0d_win%0d: got (%0d,%0d) last=%0b %h, required (%0d,%0d) last=%0b %h",
                             run, i, obs[i].row, obs[i].col, obs[i].last, obs[i].w,
                             e[i].row, e[i].col, e[i].last, e[i].w);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        pxq_t  px = seq(1, N*N);
        expq_t e  = model(px);
        run_stream(seq(1, 12), 0, 0, 0, 1'b0);
        asserts++;
        if (obs.size() != 0 || extra != 0) begin
            fails++;
            $display("FAIL partial_no_window: got %0d windows, required 0", obs.size() + extra);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        asserts++;
        if (win_valid !== 1'b0 || win_last !== 1'b0 || win_row !== '0 || win_col !== '0 || win !== '0) begin
            fails++;
            $display("FAIL midreset_state: valid=%b last=%b row=%0d col=%0d win=%h, required all 0",
                     win_valid, win_last, win_row, win_col, win);
        end
        @(negedge clk);
        rst = 1'b1;
        run_stream(px, e.size(), 0, 0, 1'b0);
        asserts++;
        if (timed_out || obs.size() != e.size() || extra != 0) begin
            fails++;
            $display("FAIL midreset_count: got %0d windows (+%0d extra), required %0d",
                     obs.size(), extra, e.size());
        end
        for (int i = 0; i < e.size() && i < obs.size(); i++) begin
            asserts++;
            if (obs[i].w !== e[i].w || obs[i].row != e[i].row || obs[i].col != e[i].col ||
                obs[i].last !== e[i].last ||
                e[i].trig >= acc_cycle.size() || obs[i].appear != acc_cycle[e[i].trig] + 1) begin
                fails++;
                $display("FAIL midreset_win%0d: got (%0d,%0d) last=%0b %h @%0d, required (%0d,%0d) last=%0b %h",
                         i, obs[i].row, obs[i].col, obs[i].last, obs[i].w, obs[i].appear,
                         e[i].row, e[i].col, e[i].last, e[i].w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_random();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
Streaming sliding-window generator sitting directly upstream of convolution. Accepts ifmap pixels one per beat in raster order (row 0 col 0 first) over a valid/ready handshake. Buffers FILTER_SIZE-1 previous rows in line buffers and emits every FILTER_SIZE x FILTER_SIZE window at stride 1 with no padding, in the exact array shape convolution takes on its ifmap-window input. Produces OFMAP_SIZE*OFMAP_SIZE windows per frame, back-to-back frames supported.

Parameters:
IP_DATA_WIDTH, 8, pixel width in bits (from yolo_params_pkg)
IFMAP_SIZE, 5, input feature-map height = width
FILTER_SIZE, 3, window height = width
OFMAP_SIZE, IFMAP_SIZE-FILTER_SIZE+1, windows per row/column (derived, not overridable)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
in_valid  in  1  pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
in_data  in  IP_DATA_WIDTH  pixel value
win_valid  out  1  window valid
win_ready  in  1  downstream accepts window when win_valid && win_ready
win  out  [FILTER_SIZE-1:0][FILTER_SIZE-1:0][IP_DATA_WIDTH-1:0]  window, win[i][j] = ifmap[r0+i][c0+j]
win_row  out  $clog2(OFMAP_SIZE)  r0, ofmap row of this window
win_col  out  $clog2(OFMAP_SIZE)  c0, ofmap column of this window
win_last  out  1  high with the final window of a frame (r0=c0=OFMAP_SIZE-1)

Behaviour:
- Reset (rst=0, async): win_valid=0, win_last=0, win_row=0, win_col=0, win=all zeros, pixel row/col counters=0. in_ready=1 once reset deasserts. Line-buffer contents are don't-care, never need clearing.
- Pixel counters: col increments per accepted pixel; at IFMAP_SIZE-1 it wraps to 0 and row increments; at row=col=IFMAP_SIZE-1 both wrap to 0 (next pixel starts the next frame). No gaps between frames required.
- Storage: FILTER_SIZE-1 line buffers of IFMAP_SIZE entries plus a FILTER_SIZE x FILTER_SIZE shift-register window. On accept at column c: window shifts one column left; new rightmost column = {linebuf[0][c], ..., linebuf[K-2][c], in_data} top to bottom; line buffers shift up at column c (linebuf[K-2][c] <= in_data).
- Emission: accepting pixel (r,c) with r>=FILTER_SIZE-1 and c>=FILTER_SIZE-1 loads output register next cycle: win_valid=1, win = rows r-K+1..r x cols c-K+1..c, win_row=r-K+1, win_col=c-K+1, win_last=(r=c=IFMAP_SIZE-1). Latency: 1 cycle from accepting pixel to win_valid.
- Stale columns from the previous row at a row wrap are never emitted (c>=K-1 guarantees K fresh shifts).
- Handshake: in_ready = !win_valid || win_ready (combinational). While win_valid && !win_ready, win/win_row/win_col/win_last hold stable and no pixel is accepted. Window consumed with no new window loaded: win_valid falls next cycle. Consume and load in the same cycle: win_valid stays 1 with new contents (full throughput, one window per cycle).
- in_valid low: counters and buffers hold; no state change.
- in_data ignored unless accepted. win contents are don't-care semantically when win_valid=0 but must hold last value (no X).
- Reset mid-frame: all state as above; next accepted pixel is treated as row 0 col 0; partial frame discarded, no window emitted from it after reset.

Decomposition:
- yolo_params_pkg: IP_DATA_WIDTH, IFMAP_SIZE, FILTER_SIZE, OFMAP_SIZE, plus new typedefs pixel_t (logic [IP_DATA_WIDTH-1:0]) and window_t (pixel_t [FILTER_SIZE-1:0][FILTER_SIZE-1:0]) shared with convolution.
- One natural sub-module: conv_line_buffer (one IFMAP_SIZE-deep row store indexed by column, write-and-read-old at same address), instantiated FILTER_SIZE-1 times; counters, window shift register and output register stay in the top.

Test Plan:
- Frame 1..25 streamed, win_ready=1 -> 9 windows in order; first {1,2,3;6,7,8;11,12,13} at (0,0) one cycle after pixel 13 accepted; last {13,14,15;18,19,20;23,24,25} at (2,2) with win_last=1 only there.
- Same frame, win_ready held 0 for 5 cycles after first window -> in_ready=0, window (0,0) stable; on release windows resume, none lost or duplicated.
- Random in_valid bubbles and random win_ready -> emitted window sequence identical to scenario 1.
- Two back-to-back frames (1..25 then 26..50) -> second frame first window {26,27,28;31,32,33;36,37,38} at (0,0).
- rst pulsed low after 12 pixels, then full frame 1..25 -> no window between reset and pixel 13 of new frame; output matches scenario 1.
- Chained into convolution with filter all 2 -> op for window (0,0) = 126, for (2,2) = 342.
